// File: rtl/ppc_issue_ctrl.sv
// Issue controller sharing one pipelined adder between two requesters: round-robin
// accept, tag pipeline for response routing, flush/drain. Optional: PPC_ISSUE_STATS_EN.
module ppc_issue_ctrl #(
    parameter int LATENCY = 6,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         add_issue,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] res_sum,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    input  logic         flush,
    output logic         flush_done,
`ifdef PPC_ISSUE_STATS_EN
    output logic [15:0]  stat_cnt0,
    output logic [15:0]  stat_cnt1,
`endif
    output logic         busy
);

    localparam int CW = $clog2(LATENCY + 3);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             retire;
    logic             last_id;
    logic [LATENCY:0] tag_valid;
    logic [LATENCY:0] tag_id;
    logic [CW-1:0]    count;

    // Round-robin: a lone requester always wins; on contention the one not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && (!req1_valid || last_id)) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign req0_ready = (state == RUN) && !flush && grant0;
    assign req1_ready = (state == RUN) && !flush && grant1;
    assign accept     = req0_ready | req1_ready;
    assign retire     = tag_valid[LATENCY];
    assign flush_done = (state == DONE);
    assign busy       = (count != '0);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = DONE;
            DONE:    state_next = flush ? DRAIN : RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            last_id <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) last_id <= req1_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_issue <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            add_issue <= accept;
            if (accept) begin
                add_a <= req1_ready ? req1_a : req0_a;
                add_b <= req1_ready ? req1_b : req0_b;
            end
        end
    end

    // NOTE: the tag pipeline is reset so ops in flight at reset can never produce a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid <= {tag_valid[LATENCY-1:0], accept};
            tag_id    <= {tag_id[LATENCY-1:0], req1_ready};
        end
    end

    // The tail tag lines up with res_sum, so the response captures both together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
        end else begin
            rsp_valid <= retire;
            if (retire) begin
                rsp_id  <= tag_id[LATENCY];
                rsp_sum <= res_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (accept && !retire) begin
            count <= count + 1'b1;
        end else if (!accept && retire) begin
            count <= count - 1'b1;
        end
    end

`ifdef PPC_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (flush_done) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (req0_ready && (stat_cnt0 != 16'hFFFF)) stat_cnt0 <= stat_cnt0 + 16'd1;
            if (req1_ready && (stat_cnt1 != 16'hFFFF)) stat_cnt1 <= stat_cnt1 + 16'd1;
        end
    end
`endif

endmodule
